snake_body_ctrl: RTL and testbench
==================================

# snake_body_ctrl

Snake movement and body-tracking stage for the game datapath. Steps the snake one cell per move period in the player-selected direction, keeps per-segment coordinates, and drives `head_x`/`head_y` into the apple-eating stage. Consumes that stage's `add_cube` to grow the body. Answers a per-pixel-cell body query for the display stage and flags game over on collisions.

## Interface
Parameters:
- `MAX_LEN`, 16: maximum segment count, range 4..32.
- `INIT_LEN`, 3: length after reset, range 2..MAX_LEN.
- `MOVE_DIV`, 12_500_000: clk cycles per move step.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `key_up`, `key_down`, `key_left`, `key_right` in 1 each: debounced direction requests, level or pulse.
- `add_cube` in 1: growth request from the apple stage; held high for long periods, so it is edge-detected.
- `q_x` in 6, `q_y` in 5: cell coordinates to query.
- `q_hit` out 1: registered; 1 if (`q_x`,`q_y`) is any visible segment.
- `head_x` out 6: head column.
- `head_y` out 6: head row; bit 5 always 0.
- `length` out 6: current segment count.
- `move_tick` out 1: one-cycle pulse in the cycle after each completed move.
- `game_over` out 1: high while in OVER.

## Operation
- Playfield interior is x 1..38, y 1..28. Walls are x=0, x=39, y=0, y=29.
- Segments: `seg[0]` is the head, `seg[1..length-1]` is the body. Entries at index length and above are don't-care.
- States:
  - WAIT (after reset): snake is static; the first valid key goes to PLAY.
  - PLAY: stepping is active.
  - OVER: everything is frozen until `rst`.
- Direction:
  - `cur_dir` is the direction of the last executed move. `nxt_dir` is the direction for the next move.
  - A key sets `nxt_dir` unless it is the opposite of `cur_dir`; opposite keys are ignored.
  - Same-cycle priority: up > down > left > right.
  - Reset direction is right.
- Move divider: counts 0..MOVE_DIV-1 only in PLAY. At terminal count it wraps to 0 and performs one step.
- Step:
  - Compute `new_head = seg[0] + nxt_dir`, where up is y-1 and right is x+1.
  - If `grow_pend` is set, then length increases by 1 (saturating at MAX_LEN) and `grow_pend` clears.
  - Shift `seg[i] <= seg[i-1]` for all i, and `seg[0] <= new_head`.
  - Set `cur_dir <= nxt_dir`.
  - When not growing, the old tail cell is vacated.
- Growth: a rising edge of `add_cube` sets `grow_pend`. A second edge before the step does not stack.
- Collision, checked before committing the step:
  - Wall hit: `new_head` lies on a wall.
  - Self hit, not growing: `new_head` equals `seg[0..length-2]`.
  - Self hit, growing: `new_head` equals `seg[0..length-1]`.
  - On any hit: go to OVER and leave segments, length and head unchanged. `move_tick` does not pulse.
- Query: `q_hit` is asserted if any i < length has `seg[i] == (q_x,q_y)`.
- Reset values:
  - head (20,15), body (19,15),(18,15).
  - length = INIT_LEN; extra initial segments continue leftward in row 15.
  - `nxt_dir` = `cur_dir` = right.
  - `grow_pend` = 0; divider = 0.
  - `q_hit`, `move_tick`, `game_over` = 0; `add_cube` edge register = 0.

## Timing
- Key to `nxt_dir`: registered on the next clk edge.
- Step: `head_x`/`head_y`/`length` update on the edge where the divider wraps. `move_tick` is high for the following cycle.
- Steps occur every MOVE_DIV cycles, measured from entry to PLAY.
- `q_hit` latency: 1 cycle from `q_x`/`q_y`.
- `add_cube` rising edge and a step in the same cycle: the edge sets `grow_pend` for the next step; the current step does not grow.
- Key arriving in the same cycle as a step: takes effect on the following step.
- `rst` asserted mid-step or in OVER: all reset values are applied on that edge.

## Configuration
- `SNAKE_WRAP_EN` defined:
  - Wall crossing wraps instead of ending the game: x 0 becomes 38, x 39 becomes 1, y 0 becomes 28, y 29 becomes 1.
  - Only self hits cause OVER.
- `SNAKE_WRAP_EN` undefined: wall hits go to OVER.

## Test plan
Bench uses MOVE_DIV=4.
- Reset, press `key_right`, wait 8 cycles → head (22,15), two `move_tick` pulses, `game_over`=0.
- In PLAY moving right, press `key_left` → ignored. Press `key_up` → next step head y decreases by 1.
- Hold `add_cube` high for 20 cycles → length goes 3→4 on exactly one step; length 4 persists.
- Drive right until x=38, then one more step → without `SNAKE_WRAP_EN`: `game_over`=1, head stays (38,15). With `SNAKE_WRAP_EN`: head (1,15).
- Grow to length 5, then steer up, left, down → self hit, `game_over`=1, no further `move_tick`.
- Query (19,15) after reset → `q_hit`=1 one cycle later. Query (10,10) → `q_hit`=0.

Source files
------------

// File: rtl/snake_body_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : snake_body_ctrl
// Brief    : Snake movement and body tracking. Steps the head one cell per
//            move period, shifts per-segment coordinates, grows on add_cube
//            rising edges, answers per-cell body queries and flags game over
//            on wall or self collisions.
//            Optional build macro SNAKE_WRAP_EN: walls wrap to the opposite
//            interior edge instead of ending the game.
// Revision : 1.0 - initial release
// ============================================================================
module snake_body_ctrl #(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int MOVE_DIV = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       add_cube,
    input  logic [5:0] q_x,
    input  logic [4:0] q_y,
    output logic       q_hit,
    output logic [5:0] head_x,
    output logic [5:0] head_y,
    output logic [5:0] length,
    output logic       move_tick,
    output logic       game_over
);

    localparam int                 c_DIV_W    = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(MOVE_DIV - 1);
    localparam logic [5:0]         c_MAX_LEN  = 6'(MAX_LEN);
    localparam logic [5:0]         c_INIT_LEN = 6'(INIT_LEN);

    // Direction encoding: bit 0 flipped gives the opposite direction.
    localparam logic [1:0] c_DIR_UP    = 2'd0;
    localparam logic [1:0] c_DIR_DOWN  = 2'd1;
    localparam logic [1:0] c_DIR_LEFT  = 2'd2;
    localparam logic [1:0] c_DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [5:0]           r_seg_x [MAX_LEN];
    logic [4:0]           r_seg_y [MAX_LEN];
    logic [5:0]           r_len;
    logic [1:0]           r_cur_dir;
    logic [1:0]           r_nxt_dir;
    logic                 r_grow_pend;
    logic                 r_add_q;
    logic [c_DIV_W-1:0]   r_div;
    logic                 r_q_hit;
    logic                 r_move_tick;

    logic                 w_key_any;
    logic [1:0]           w_key_dir;
    logic                 w_key_valid;
    logic                 w_add_rise;
    logic [5:0]           w_nh_x;
    logic [4:0]           w_nh_y;
    logic [5:0]           w_step_x;
    logic [4:0]           w_step_y;
    logic                 w_wall_coll;
    logic                 w_growing;
    logic [5:0]           w_body_lim;
    logic [MAX_LEN-1:0]   w_self_match;
    logic [MAX_LEN-1:0]   w_q_match;
    logic                 w_coll;
    logic                 w_div_term;
    logic                 w_step_due;
    logic                 w_step;

    assign w_add_rise  = add_cube & ~r_add_q;
    assign w_key_valid = w_key_any && (w_key_dir != (r_cur_dir ^ 2'b01));

    // Pick the highest-priority pressed key: up > down > left > right.
    always_comb begin
        w_key_any = 1'b1;
        w_key_dir = c_DIR_RIGHT;
        if (key_up)         w_key_dir = c_DIR_UP;
        else if (key_down)  w_key_dir = c_DIR_DOWN;
        else if (key_left)  w_key_dir = c_DIR_LEFT;
        else if (key_right) w_key_dir = c_DIR_RIGHT;
        else                w_key_any = 1'b0;
    end

    // Candidate head cell one step along the pending direction.
    always_comb begin
        w_nh_x = r_seg_x[0];
        w_nh_y = r_seg_y[0];
        case (r_nxt_dir)
            c_DIR_UP:    w_nh_y = r_seg_y[0] - 5'd1;
            c_DIR_DOWN:  w_nh_y = r_seg_y[0] + 5'd1;
            c_DIR_LEFT:  w_nh_x = r_seg_x[0] - 6'd1;
            default:     w_nh_x = r_seg_x[0] + 6'd1;
        endcase
    end

`ifdef SNAKE_WRAP_EN
    // Walls fold the head back onto the opposite interior edge.
    assign w_step_x    = (w_nh_x == 6'd0)  ? 6'd38 : (w_nh_x == 6'd39) ? 6'd1 : w_nh_x;
    assign w_step_y    = (w_nh_y == 5'd0)  ? 5'd28 : (w_nh_y == 5'd29) ? 5'd1 : w_nh_y;
    assign w_wall_coll = 1'b0;
`else
    assign w_step_x    = w_nh_x;
    assign w_step_y    = w_nh_y;
    assign w_wall_coll = (w_nh_x == 6'd0) || (w_nh_x == 6'd39) ||
                         (w_nh_y == 5'd0) || (w_nh_y == 5'd29);
`endif

    // A saturated snake still drops its tail, so it only counts as growing
    // (tail cell stays occupied) while below MAX_LEN.
    assign w_growing  = r_grow_pend && (r_len < c_MAX_LEN);
    assign w_body_lim = w_growing ? r_len : (r_len - 6'd1);

    for (genvar i = 0; i < MAX_LEN; i++) begin : g_seg_cmp
        assign w_self_match[i] = (6'(i) < w_body_lim) &&
                                 (r_seg_x[i] == w_step_x) && (r_seg_y[i] == w_step_y);
        assign w_q_match[i]    = (6'(i) < r_len) &&
                                 (r_seg_x[i] == q_x) && (r_seg_y[i] == q_y);
    end

    assign w_coll     = w_wall_coll | (|w_self_match);
    assign w_div_term = (r_div == c_DIV_LAST);
    assign w_step_due = (r_state == ST_PLAY) && w_div_term;
    assign w_step     = w_step_due && !w_coll;

    // Game state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_WAIT;
        else     r_state <= w_state_nxt;
    end

    // Next-state decode and game_over flag.
    always_comb begin
        w_state_nxt = r_state;
        game_over   = 1'b0;
        case (r_state)
            ST_WAIT: if (w_key_valid) w_state_nxt = ST_PLAY;
            ST_PLAY: if (w_step_due && w_coll) w_state_nxt = ST_OVER;
            ST_OVER: game_over = 1'b1;
            default: w_state_nxt = ST_WAIT;
        endcase
    end

    // Move-period divider, running only while playing.
    always_ff @(posedge clk) begin
        if (rst)                   r_div <= '0;
        else if (r_state == ST_PLAY) r_div <= w_div_term ? '0 : (r_div + c_DIV_W'(1));
    end

    // Direction latching and growth request tracking; frozen in OVER.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_dir   <= c_DIR_RIGHT;
            r_nxt_dir   <= c_DIR_RIGHT;
            r_grow_pend <= 1'b0;
            r_add_q     <= 1'b0;
        end else begin
            r_add_q <= add_cube;
            if (r_state != ST_OVER) begin
                if (w_key_valid) r_nxt_dir <= w_key_dir;
                if (w_step) begin
                    r_cur_dir   <= r_nxt_dir;
                    // An edge coincident with a step arms the following step.
                    r_grow_pend <= w_add_rise;
                end else if (w_add_rise) begin
                    r_grow_pend <= 1'b1;
                end
            end
        end
    end

    // Segment count, saturating at MAX_LEN.
    always_ff @(posedge clk) begin
        if (rst)                    r_len <= c_INIT_LEN;
        else if (w_step && w_growing) r_len <= r_len + 6'd1;
    end

    // Segment shift register: head takes the new cell, body follows.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= (i < INIT_LEN) ? 6'(20 - i) : 6'd0;
                r_seg_y[i] <= (i < INIT_LEN) ? 5'd15 : 5'd0;
            end
        end else if (w_step) begin
            r_seg_x[0] <= w_step_x;
            r_seg_y[0] <= w_step_y;
            for (int i = 1; i < MAX_LEN; i++) begin
                r_seg_x[i] <= r_seg_x[i-1];
                r_seg_y[i] <= r_seg_y[i-1];
            end
        end
    end

    // Registered body query and move pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q_hit     <= 1'b0;
            r_move_tick <= 1'b0;
        end else begin
            r_q_hit     <= |w_q_match;
            r_move_tick <= w_step;
        end
    end

    assign q_hit     = r_q_hit;
    assign move_tick = r_move_tick;
    assign head_x    = r_seg_x[0];
    assign head_y    = {1'b0, r_seg_y[0]};
    assign length    = r_len;

endmodule
`default_nettype wire

// File: tb/tb_snake_body_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_snake_body_ctrl
// Brief    : Directed vector bench for snake_body_ctrl with MOVE_DIV = 4.
//            Honours SNAKE_WRAP_EN for the wall-crossing expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snake_body_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_up, key_down, key_left, key_right;
    logic       add_cube;
    logic [5:0] q_x;
    logic [4:0] q_y;
    logic       q_hit;
    logic [5:0] head_x;
    logic [5:0] head_y;
    logic [5:0] length;
    logic       move_tick;
    logic       game_over;

    int vec_cnt = 0;
    int err_cnt = 0;

    // One row: optional reset, key pulse {up,down,left,right} and add_cube
    // pulse on the first cycle, cycle count, then expected state.
    typedef struct {
        logic       rst;
        logic [3:0] key;
        logic       add;
        int         ncyc;
        int         hx;
        int         hy;
        int         len;
        logic       go;
        int         ticks;
    } vec_t;

    typedef struct {
        int   qx;
        int   qy;
        logic hit;
    } qvec_t;

    vec_t  vecs  [21];
    qvec_t qvecs [7];

    snake_body_ctrl #(
        .MAX_LEN  (16),
        .INIT_LEN (3),
        .MOVE_DIV (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_up    (key_up),
        .key_down  (key_down),
        .key_left  (key_left),
        .key_right (key_right),
        .add_cube  (add_cube),
        .q_x       (q_x),
        .q_y       (q_y),
        .q_hit     (q_hit),
        .head_x    (head_x),
        .head_y    (head_y),
        .length    (length),
        .move_tick (move_tick),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v, input int idx);
        int ticks;
        ticks = 0;
        if (v.rst) begin
            rst = 1'b1;
            step_clk();
            rst = 1'b0;
        end
        {key_up, key_down, key_left, key_right} = v.key;
        add_cube = v.add;
        for (int c = 0; c < v.ncyc; c++) begin
            step_clk();
            if (move_tick) ticks++;
            if (c == 0) begin
                {key_up, key_down, key_left, key_right} = 4'b0000;
                add_cube = 1'b0;
            end
        end
        check($sformatf("v%0d.head_x", idx), int'(head_x), v.hx);
        check($sformatf("v%0d.head_y", idx), int'(head_y), v.hy);
        check($sformatf("v%0d.length", idx), int'(length), v.len);
        check($sformatf("v%0d.game_over", idx), int'(game_over), int'(v.go));
        check($sformatf("v%0d.ticks", idx), ticks, v.ticks);
    endtask

    initial begin
        int len_changes;
        int prev_len;

        //          rst   key      add   ncyc hx  hy len go    ticks
        vecs[0]  = '{1'b1, 4'b0001, 1'b0, 9,  22, 15, 3, 1'b0, 2};
        vecs[1]  = '{1'b0, 4'b0010, 1'b0, 4,  23, 15, 3, 1'b0, 1};
        vecs[2]  = '{1'b0, 4'b1000, 1'b0, 4,  23, 14, 3, 1'b0, 1};
        vecs[3]  = '{1'b0, 4'b0001, 1'b1, 4,  24, 14, 4, 1'b0, 1};
        vecs[4]  = '{1'b0, 4'b0000, 1'b0, 8,  26, 14, 4, 1'b0, 2};
`ifdef SNAKE_WRAP_EN
        vecs[5]  = '{1'b1, 4'b0001, 1'b0, 77, 1,  15, 3, 1'b0, 19};
        vecs[6]  = '{1'b0, 4'b0000, 1'b0, 8,  3,  15, 3, 1'b0, 2};
`else
        vecs[5]  = '{1'b1, 4'b0001, 1'b0, 77, 38, 15, 3, 1'b1, 18};
        vecs[6]  = '{1'b0, 4'b0000, 1'b0, 8,  38, 15, 3, 1'b1, 0};
`endif
        vecs[7]  = '{1'b1, 4'b0001, 1'b1, 5,  21, 15, 4, 1'b0, 1};
        vecs[8]  = '{1'b0, 4'b1000, 1'b0, 4,  21, 14, 4, 1'b0, 1};
        vecs[9]  = '{1'b0, 4'b0010, 1'b0, 4,  20, 14, 4, 1'b0, 1};
        vecs[10] = '{1'b0, 4'b0100, 1'b0, 4,  20, 15, 4, 1'b0, 1};
        vecs[11] = '{1'b0, 4'b0001, 1'b1, 4,  20, 15, 4, 1'b1, 0};
        vecs[12] = '{1'b0, 4'b0000, 1'b0, 8,  20, 15, 4, 1'b1, 0};
        vecs[13] = '{1'b1, 4'b0001, 1'b1, 5,  21, 15, 4, 1'b0, 1};
        vecs[14] = '{1'b0, 4'b0000, 1'b1, 4,  22, 15, 5, 1'b0, 1};
        vecs[15] = '{1'b0, 4'b1000, 1'b0, 4,  22, 14, 5, 1'b0, 1};
        vecs[16] = '{1'b0, 4'b0010, 1'b0, 4,  21, 14, 5, 1'b0, 1};
        vecs[17] = '{1'b0, 4'b0100, 1'b0, 4,  21, 14, 5, 1'b1, 0};
        vecs[18] = '{1'b0, 4'b0000, 1'b0, 8,  21, 14, 5, 1'b1, 0};
        vecs[19] = '{1'b1, 4'b0010, 1'b0, 8,  20, 15, 3, 1'b0, 0};
        vecs[20] = '{1'b0, 4'b1000, 1'b0, 5,  20, 14, 3, 1'b0, 1};

        qvecs[0] = '{19, 15, 1'b1};
        qvecs[1] = '{10, 10, 1'b0};
        qvecs[2] = '{20, 15, 1'b1};
        qvecs[3] = '{18, 15, 1'b1};
        qvecs[4] = '{17, 15, 1'b0};
        qvecs[5] = '{0,  0,  1'b0};
        qvecs[6] = '{21, 15, 1'b0};

        rst = 1'b1;
        {key_up, key_down, key_left, key_right} = 4'b0000;
        add_cube = 1'b0;
        q_x = 6'd0;
        q_y = 5'd0;
        repeat (3) step_clk();
        rst = 1'b0;

        check("rst.head_x", int'(head_x), 20);
        check("rst.head_y", int'(head_y), 15);
        check("rst.length", int'(length), 3);
        check("rst.game_over", int'(game_over), 0);
        check("rst.move_tick", int'(move_tick), 0);
        check("rst.q_hit", int'(q_hit), 0);

        for (int i = 0; i < 7; i++) begin
            q_x = 6'(qvecs[i].qx);
            q_y = 5'(qvecs[i].qy);
            step_clk();
            check($sformatf("q%0d.q_hit", i), int'(q_hit), int'(qvecs[i].hit));
        end
        // Query output must not follow the inputs before the next edge.
        q_x = 6'd19;
        q_y = 5'd15;
        #2;
        check("q_lat.before_edge", int'(q_hit), 0);
        step_clk();
        check("q_lat.after_edge", int'(q_hit), 1);

        for (int i = 0; i < 21; i++) apply(vecs[i], i);

        // Key and add_cube edge landing in the same cycle as a step.
        repeat (3) step_clk();
        key_left = 1'b1;
        add_cube = 1'b1;
        step_clk();
        key_left = 1'b0;
        add_cube = 1'b0;
        check("same_cyc.head_x", int'(head_x), 20);
        check("same_cyc.head_y", int'(head_y), 13);
        check("same_cyc.length", int'(length), 3);
        check("same_cyc.move_tick", int'(move_tick), 1);
        repeat (4) step_clk();
        check("next_step.head_x", int'(head_x), 19);
        check("next_step.head_y", int'(head_y), 13);
        check("next_step.length", int'(length), 4);

        // add_cube held high: exactly one growth.
        len_changes = 0;
        prev_len = int'(length);
        add_cube = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step_clk();
            if (int'(length) != prev_len) len_changes++;
            prev_len = int'(length);
        end
        add_cube = 1'b0;
        check("hold_add.changes", len_changes, 1);
        check("hold_add.length", int'(length), 5);
        check("hold_add.head_x", int'(head_x), 14);
        repeat (4) step_clk();
        check("hold_add.persist_len", int'(length), 5);
        check("hold_add.persist_x", int'(head_x), 13);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
